// File: rtl/md5_pkg.sv
// Shared definitions for the MD5 match path: window length, sequencer
// state encodings and the command opcodes decoded by cmd_parser.
package md5_pkg;

  localparam int STR_LEN = 19;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_ISSUE = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [7:0] OP_SET_HASH  = 8'h01;
  localparam logic [7:0] OP_SEND_TEXT = 8'h02;
  localparam logic [7:0] OP_QUERY     = 8'h03;

endpackage

// File: rtl/window_shift_reg.sv
// Byte-wide shift register holding one sliding window; the newest byte
// enters at the LS end so the oldest byte sits in the MS byte.
module window_shift_reg #(
  parameter int BYTES = md5_pkg::STR_LEN
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [7:0]         i_byte,
  output logic [BYTES*8-1:0] o_window
);
  import md5_pkg::*;

  logic [BYTES*8-1:0] r_win;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_win <= '0;
    end else if (i_en) begin
      r_win <= {r_win[BYTES*8-9:0], i_byte};
    end
  end

  assign o_window = r_win;

endmodule

// File: rtl/md5_window_sched.sv
// Sequencer for one SEND_TEXT block: slides a STR_LEN-byte window over the
// text buffer, feeds the in-order MD5 core and records the first digest hit.
module md5_window_sched #(
  parameter int STR_LEN = md5_pkg::STR_LEN,
  parameter int ADDR_W  = 8,
  parameter int MAX_OUT = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [15:0]          text_len,
  input  logic [127:0]         target_hash,
  output logic [ADDR_W-1:0]    buf_addr,
  input  logic [7:0]           buf_data,
  output logic                 md5_in_valid,
  input  logic                 md5_in_ready,
  output logic [STR_LEN*8-1:0] md5_in_msg,
  input  logic                 md5_out_valid,
  input  logic [127:0]         md5_out_digest,
  input  logic [STR_LEN*8-1:0] md5_out_msg,
  output logic                 busy,
  output logic                 done,
  output logic                 match,
  output logic [15:0]          match_pos,
  output logic [STR_LEN*8-1:0] match_str,
  output logic [2:0]           dbg_state
);
  import md5_pkg::*;

  localparam int              OC_W      = $clog2(MAX_OUT + 1);
  localparam int              MW        = STR_LEN * 8;
  localparam logic [OC_W-1:0] MAX_OUT_C = OC_W'(MAX_OUT);
  localparam logic [15:0]     STR_LEN_C = 16'(STR_LEN);
  localparam logic [15:0]     POS_OFF_C = 16'(STR_LEN - 1);

  logic [2:0]      r_state;
  logic [15:0]     r_rd_cnt;
  logic [15:0]     r_res_cnt;
  logic [OC_W-1:0] r_out_cnt;
  logic [15:0]     r_text_len;
  logic [127:0]    r_target;
  logic            r_match;
  logic [15:0]     r_match_pos;
  logic [MW-1:0]   r_match_str;

  logic            w_in_valid;
  logic            w_accept;
  logic            w_hit;
  logic            w_shift_en;
  logic [MW-1:0]   w_window;

  // Handshake: a window transfers on a cycle where md5_in_valid and
  // md5_in_ready are both high; the window is held until then, but the offer
  // is withdrawn once a match is known or the core holds MAX_OUT windows.
  assign w_in_valid = (r_state == ST_ISSUE) && (r_out_cnt < MAX_OUT_C) && !r_match;
  assign w_accept   = w_in_valid && md5_in_ready;
  assign w_hit      = md5_out_valid && (md5_out_digest == r_target) && !r_match;
  assign w_shift_en = (r_state == ST_SHIFT);

  window_shift_reg #(
    .BYTES (STR_LEN)
  ) u_window (
    .i_clk    (clk),
    .i_rst_n  (reset_n),
    .i_en     (w_shift_en),
    .i_byte   (buf_data),
    .o_window (w_window)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_rd_cnt    <= '0;
      r_res_cnt   <= '0;
      r_out_cnt   <= '0;
      r_text_len  <= '0;
      r_target    <= '0;
      r_match     <= 1'b0;
      r_match_pos <= '0;
      r_match_str <= '0;
    end else begin
      // Result path runs in every state; an accept and a result in the same
      // cycle leave the in-flight count unchanged.
      if (w_accept && !md5_out_valid) begin
        r_out_cnt <= r_out_cnt + 1'b1;
      end else if (!w_accept && md5_out_valid) begin
        r_out_cnt <= r_out_cnt - 1'b1;
      end
      if (md5_out_valid) begin
        r_res_cnt <= r_res_cnt + 16'd1;
      end
      if (w_hit) begin
        r_match     <= 1'b1;
        r_match_pos <= r_res_cnt + POS_OFF_C;
        r_match_str <= md5_out_msg;
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_match     <= 1'b0;
            r_match_pos <= '0;
            r_match_str <= '0;
            r_rd_cnt    <= '0;
            r_res_cnt   <= '0;
            r_out_cnt   <= '0;
            r_text_len  <= text_len;
            r_target    <= target_hash;
            r_state     <= (text_len < STR_LEN_C) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_rd_cnt <= r_rd_cnt + 16'd1;
          r_state  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_state <= (r_rd_cnt >= STR_LEN_C) ? ST_ISSUE : ST_FETCH;
        end
        ST_ISSUE: begin
          if (r_match) begin
            r_state <= ST_DRAIN;
          end else if (w_accept) begin
            // The next byte address goes out with the accept, so the
            // following SHIFT already sees its data.
            if (r_rd_cnt == r_text_len) begin
              r_state <= ST_DRAIN;
            end else begin
              r_rd_cnt <= r_rd_cnt + 16'd1;
              r_state  <= ST_SHIFT;
            end
          end
        end
        ST_DRAIN: begin
          if (r_out_cnt == '0) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign buf_addr     = r_rd_cnt[ADDR_W-1:0];
  assign md5_in_valid = w_in_valid;
  assign md5_in_msg   = w_window;
  assign busy         = (r_state != ST_IDLE);
  assign done         = (r_state == ST_DONE);
  assign match        = r_match;
  assign match_pos    = r_match_pos;
  assign match_str    = r_match_str;
  assign dbg_state    = r_state;

endmodule
